// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program-counter generator.
// Holds the fetch PC and selects the next PC from trap, redirect,
// return-address-stack prediction or sequential increment.
// Ports:
//   clk, rst (async, active-low)
//   stall, trap_valid/trap_target, redirect_valid/redirect_target
//   ras_push, ras_pop, halt, resume
//   pc (registered), pc_next (combinational), pc_valid,
//   ras_empty, ras_full (registered)
module pc_unit #(
    parameter int unsigned     XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(0),
    parameter int unsigned     INC          = 4,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            ras_push,
    input  logic            ras_pop,
    input  logic            halt,
    input  logic            resume,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next,
    output logic            pc_valid,
    output logic            ras_empty,
    output logic            ras_full
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] top;
    logic [PTR_W-1:0] top_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic [XLEN-1:0]  pc_inc;
    logic [XLEN-1:0]  ras_top;
    logic             ras_has;

    // Instruction addresses are at least halfword aligned.
    function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:1], 1'b0};
    endfunction

    assign pc_inc  = pc + XLEN'(INC);
    assign ras_top = align(ras_mem[top]);
    assign ras_has = (cnt != CNT_W'(0));

    // Next-state, next-PC and RAS update selection.
    always_comb begin
        state_nxt = state;
        pc_next   = pc;
        cnt_nxt   = cnt;
        top_nxt   = top;
        wr_en     = 1'b0;
        wr_idx    = top;

        case (state)
            ST_BOOT: begin
                state_nxt = ST_RUN;
            end

            ST_RUN: begin
                if (trap_valid) begin
                    pc_next = align(trap_target);
                    cnt_nxt = CNT_W'(0);
                    top_nxt = PTR_W'(0);
                end else begin
                    if (halt) begin
                        state_nxt = ST_HALTED;
                    end

                    if (redirect_valid) begin
                        pc_next = align(redirect_target);
                    end else if (stall) begin
                        pc_next = pc;
                    end else if (ras_pop && ras_has) begin
                        pc_next = ras_top;
                    end else begin
                        pc_next = pc_inc;
                    end

                    // A redirect does not block the RAS; a stall does.
                    if (!stall) begin
                        if (ras_push && ras_pop && ras_has) begin
                            wr_en  = 1'b1;
                            wr_idx = top;
                        end else if (ras_push) begin
                            // Circular: when full the oldest entry is overwritten.
                            wr_en   = 1'b1;
                            wr_idx  = top + PTR_W'(1);
                            top_nxt = top + PTR_W'(1);
                            if (cnt != CNT_FULL) begin
                                cnt_nxt = cnt + CNT_W'(1);
                            end
                        end else if (ras_pop && ras_has) begin
                            top_nxt = top - PTR_W'(1);
                            cnt_nxt = cnt - CNT_W'(1);
                        end
                    end
                end
            end

            ST_HALTED: begin
                // A trap is the one way pc changes while halted.
                if (trap_valid) begin
                    pc_next   = align(trap_target);
                    cnt_nxt   = CNT_W'(0);
                    top_nxt   = PTR_W'(0);
                    state_nxt = ST_RUN;
                end else if (resume) begin
                    state_nxt = ST_RUN;
                end
            end

            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
    end

    // State, PC, RAS pointers and registered qualifiers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_BOOT;
            pc        <= RESET_VECTOR;
            cnt       <= CNT_W'(0);
            top       <= PTR_W'(0);
            pc_valid  <= 1'b0;
            ras_empty <= 1'b1;
            ras_full  <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_next;
            cnt       <= cnt_nxt;
            top       <= top_nxt;
            pc_valid  <= (state_nxt == ST_RUN);
            ras_empty <= (cnt_nxt == CNT_W'(0));
            ras_full  <= (cnt_nxt == CNT_FULL);
        end
    end

    // RAS storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ras_mem[wr_idx] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench for pc_unit (XLEN=64, RESET_VECTOR=0x1000,
// INC=4, RAS_DEPTH=4).
module tb_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        trap_valid;
    logic [63:0] trap_target;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        ras_push;
    logic        ras_pop;
    logic        halt;
    logic        resume;
    logic [63:0] pc;
    logic [63:0] pc_next;
    logic        pc_valid;
    logic        ras_empty;
    logic        ras_full;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [63:0] pc;
        logic        valid;
        logic        empty;
        logic        full;
    } exp_t;

    exp_t sb[$];

    pc_unit #(
        .XLEN         (64),
        .RESET_VECTOR (64'h1000),
        .INC          (4),
        .RAS_DEPTH    (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .trap_valid      (trap_valid),
        .trap_target     (trap_target),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .ras_push        (ras_push),
        .ras_pop         (ras_pop),
        .halt            (halt),
        .resume          (resume),
        .pc              (pc),
        .pc_next         (pc_next),
        .pc_valid        (pc_valid),
        .ras_empty       (ras_empty),
        .ras_full        (ras_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        stall           = 1'b0;
        trap_valid      = 1'b0;
        trap_target     = 64'h0;
        redirect_valid  = 1'b0;
        redirect_target = 64'h0;
        ras_push        = 1'b0;
        ras_pop         = 1'b0;
        halt            = 1'b0;
        resume          = 1'b0;
    endtask

    task automatic redir(input logic [63:0] a);
        redirect_valid  = 1'b1;
        redirect_target = a;
    endtask

    // Push the expected post-edge state, clock once, pop and compare.
    task automatic tick(input string tag, input logic [63:0] epc,
                        input logic ev, input logic ee, input logic ef);
        exp_t e;
        e = '{pc: epc, valid: ev, empty: ee, full: ef};
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check({tag, ".pc"},    pc,               e.pc);
            check({tag, ".valid"}, 64'(pc_valid),    64'(e.valid));
            check({tag, ".empty"}, 64'(ras_empty),   64'(e.empty));
            check({tag, ".full"},  64'(ras_full),    64'(e.full));
        end
        idle();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.pc",      pc,              64'h1000);
        check("rst.pc_next", pc_next,         64'h1000);
        check("rst.valid",   64'(pc_valid),   64'd0);
        check("rst.empty",   64'(ras_empty),  64'd1);
        check("rst.full",    64'(ras_full),   64'd0);

        // BOOT: one cycle, inputs ignored.
        rst = 1'b1;
        #1;
        check("boot.pc",    pc,            64'h1000);
        check("boot.valid", 64'(pc_valid), 64'd0);
        redir(64'h5000);
        trap_valid = 1'b1; trap_target = 64'h6000;
        tick("boot_exit", 64'h1000, 1'b1, 1'b1, 1'b0);
        tick("seq0",      64'h1004, 1'b1, 1'b1, 1'b0);

        // Priority: trap > redirect > stall, trap flushes RAS and ignores halt.
        redir(64'h2000); ras_push = 1'b1;
        tick("redir_push", 64'h2000, 1'b1, 1'b0, 1'b0);
        trap_valid = 1'b1; trap_target = 64'h8000;
        redir(64'h3000); stall = 1'b1; halt = 1'b1;
        #1;
        check("prio_trap.pc_next", pc_next, 64'h8000);
        tick("prio_trap", 64'h8000, 1'b1, 1'b1, 1'b0);
        redir(64'h2000);
        tick("back2000", 64'h2000, 1'b1, 1'b1, 1'b0);
        redir(64'h3000); stall = 1'b1;
        tick("prio_redir", 64'h3000, 1'b1, 1'b1, 1'b0);
        redir(64'h2000);
        tick("back2000b", 64'h2000, 1'b1, 1'b1, 1'b0);
        stall = 1'b1; ras_push = 1'b1;
        #1;
        check("stall.pc_next", pc_next, 64'h2000);
        tick("stall_push", 64'h2000, 1'b1, 1'b1, 1'b0);
        stall = 1'b1;
        tick("stall", 64'h2000, 1'b1, 1'b1, 1'b0);

        // RAS call/return with aligned redirect.
        redir(64'h100);
        tick("to100", 64'h100, 1'b1, 1'b1, 1'b0);
        redir(64'h401); ras_push = 1'b1;
        #1;
        check("align.pc_next", pc_next, 64'h400);
        tick("call", 64'h400, 1'b1, 1'b0, 1'b0);
        tick("seq404", 64'h404, 1'b1, 1'b0, 1'b0);
        ras_pop = 1'b1;
        #1;
        check("ret.pc_next", pc_next, 64'h104);
        tick("ret", 64'h104, 1'b1, 1'b1, 1'b0);
        ras_pop = 1'b1;
        tick("pop_empty", 64'h108, 1'b1, 1'b1, 1'b0);

        // Overflow: five pushes into four entries.
        redir(64'h10);
        tick("to10", 64'h10, 1'b1, 1'b1, 1'b0);
        redir(64'h20);   ras_push = 1'b1; tick("push1", 64'h20,   1'b1, 1'b0, 1'b0);
        redir(64'h30);   ras_push = 1'b1; tick("push2", 64'h30,   1'b1, 1'b0, 1'b0);
        redir(64'h40);   ras_push = 1'b1; tick("push3", 64'h40,   1'b1, 1'b0, 1'b0);
        redir(64'h50);   ras_push = 1'b1; tick("push4", 64'h50,   1'b1, 1'b0, 1'b1);
        redir(64'h1000); ras_push = 1'b1; tick("push5", 64'h1000, 1'b1, 1'b0, 1'b1);
        ras_pop = 1'b1; tick("pop1", 64'h54, 1'b1, 1'b0, 1'b0);
        ras_pop = 1'b1; tick("pop2", 64'h44, 1'b1, 1'b0, 1'b0);
        ras_pop = 1'b1; tick("pop3", 64'h34, 1'b1, 1'b0, 1'b0);
        ras_pop = 1'b1; tick("pop4", 64'h24, 1'b1, 1'b1, 1'b0);
        ras_pop = 1'b1; tick("pop5", 64'h28, 1'b1, 1'b1, 1'b0);

        // Push+pop together: replace top when non-empty, plain push when empty.
        ras_push = 1'b1;                 tick("pp_push",  64'h2c, 1'b1, 1'b0, 1'b0);
        ras_push = 1'b1; ras_pop = 1'b1; tick("pp_both",  64'h2c, 1'b1, 1'b0, 1'b0);
        ras_pop = 1'b1;                  tick("pp_pop",   64'h30, 1'b1, 1'b1, 1'b0);
        ras_push = 1'b1; ras_pop = 1'b1; tick("pp_empty", 64'h34, 1'b1, 1'b0, 1'b0);
        ras_pop = 1'b1;                  tick("pp_pop2",  64'h34, 1'b1, 1'b1, 1'b0);

        // Halt / resume.
        redir(64'h200);
        tick("to200", 64'h200, 1'b1, 1'b1, 1'b0);
        halt = 1'b1;
        tick("halt", 64'h204, 1'b0, 1'b1, 1'b0);
        tick("halted1", 64'h204, 1'b0, 1'b1, 1'b0);
        redir(64'h9000); stall = 1'b1; ras_push = 1'b1;
        tick("halted2", 64'h204, 1'b0, 1'b1, 1'b0);
        halt = 1'b1;
        tick("halted3", 64'h204, 1'b0, 1'b1, 1'b0);
        tick("halted4", 64'h204, 1'b0, 1'b1, 1'b0);
        halt = 1'b1; resume = 1'b1;
        tick("resume", 64'h204, 1'b1, 1'b1, 1'b0);
        tick("seq208", 64'h208, 1'b1, 1'b1, 1'b0);
        ras_push = 1'b1;
        tick("push208", 64'h20c, 1'b1, 1'b0, 1'b0);
        halt = 1'b1; redir(64'h600);
        tick("halt_redir", 64'h600, 1'b0, 1'b0, 1'b0);
        trap_valid = 1'b1; trap_target = 64'h701;
        tick("halt_trap", 64'h700, 1'b1, 1'b1, 1'b0);

        // Wrap at top of address space.
        redir(64'hFFFF_FFFF_FFFF_FFFC);
        tick("to_top", 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1, 1'b0);
        tick("wrap", 64'h0, 1'b1, 1'b1, 1'b0);
        ras_push = 1'b1;
        tick("push0", 64'h4, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset between edges.
        #2;
        rst = 1'b0;
        #1;
        check("arst.pc",    pc,             64'h1000);
        check("arst.valid", 64'(pc_valid),  64'd0);
        check("arst.empty", 64'(ras_empty), 64'd1);
        check("arst.full",  64'(ras_full),  64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick("reboot", 64'h1000, 1'b1, 1'b1, 1'b0);
        tick("reboot_seq", 64'h1004, 1'b1, 1'b1, 1'b0);

        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
